// File: rtl/apb_timer_pkg.sv
// Shared definitions for the APB timer: register offsets, CTRL bit positions,
// default widths and the word-address decoder.
package apb_timer_pkg;

  localparam int DEF_CNT_W = 32;
  localparam int DEF_PRE_W = 8;

  localparam logic [11:0] TMR_CTRL  = 12'h000;
  localparam logic [11:0] TMR_COUNT = 12'h004;
  localparam logic [11:0] TMR_CMP   = 12'h008;
  localparam logic [11:0] TMR_STAT  = 12'h00C;

  localparam int CTRL_EN_BIT         = 0;
  localparam int CTRL_AUTORELOAD_BIT = 1;
  localparam int CTRL_IRQ_EN_BIT     = 2;
  localparam int CTRL_PRESC_LSB      = 8;

  typedef enum logic [2:0] {
    REG_CTRL,
    REG_COUNT,
    REG_CMP,
    REG_STAT,
    REG_NONE
  } reg_sel_e;

  // Byte-lane bits are ignored; anything outside the four words is REG_NONE.
  function automatic reg_sel_e decode_addr(input logic [11:0] addr);
    logic [11:0] word;
    word = {addr[11:2], 2'b00};
    case (word)
      TMR_CTRL:  return REG_CTRL;
      TMR_COUNT: return REG_COUNT;
      TMR_CMP:   return REG_CMP;
      TMR_STAT:  return REG_STAT;
      default:   return REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/apb_timer_core.sv
// Timer datapath: prescaler, free-running/auto-reload COUNT and sticky MATCH flag.
module apb_timer_core
  import apb_timer_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int PRE_W = DEF_PRE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             autoreload,
  input  logic [PRE_W-1:0] presc,
  input  logic [CNT_W-1:0] cmp,
  input  logic             count_we,
  input  logic [CNT_W-1:0] count_wdata,
  input  logic             match_clr,
  output logic [CNT_W-1:0] count,
  output logic             match
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [PRE_W-1:0] PRE_ONE = 1;

  logic [PRE_W-1:0] pre_cnt;
  logic             tick;
  logic             hit;

  // >= rather than == so that lowering PRESC mid-count ticks immediately.
  assign tick = en & (pre_cnt >= presc);
  assign hit  = (count == cmp);

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt <= '0;
      count   <= '0;
      match   <= 1'b0;
    end else begin
      if (!en || count_we || tick) pre_cnt <= '0;
      else                         pre_cnt <= pre_cnt + PRE_ONE;

      if (count_we)  count <= count_wdata;
      else if (tick) count <= (hit && autoreload) ? '0 : count + CNT_ONE;

      // A match set takes priority over a simultaneous software clear.
      if (tick && hit)    match <= 1'b1;
      else if (match_clr) match <= 1'b0;
    end
  end

endmodule

// File: rtl/apb_timer.sv
// APB3 completer wrapping the timer core: one-wait-state handshake, register
// decode, CTRL/CMP storage and the registered read path.
module apb_timer
  import apb_timer_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int PRE_W = DEF_PRE_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] paddr,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] pwdata,
  output logic        pready,
  output logic [31:0] prdata,
  output logic        pslverr,
  output logic        irq
);

  reg_sel_e         sel;
  logic             access;
  logic             wr_commit;
  logic             ctrl_en;
  logic             ctrl_autoreload;
  logic             ctrl_irq_en;
  logic [PRE_W-1:0] ctrl_presc;
  logic [CNT_W-1:0] cmp_q;
  logic [CNT_W-1:0] count;
  logic             match;
  logic [31:0]      rd_mux;

  assign sel       = decode_addr(paddr);
  assign access    = psel & penable & ~pready;
  assign wr_commit = psel & penable & pready & pwrite;

  always_comb begin
    rd_mux = '0;
    case (sel)
      REG_CTRL: begin
        rd_mux[CTRL_EN_BIT]                  = ctrl_en;
        rd_mux[CTRL_AUTORELOAD_BIT]          = ctrl_autoreload;
        rd_mux[CTRL_IRQ_EN_BIT]              = ctrl_irq_en;
        rd_mux[CTRL_PRESC_LSB +: PRE_W]      = ctrl_presc;
      end
      REG_COUNT: rd_mux[CNT_W-1:0] = count;
      REG_CMP:   rd_mux[CNT_W-1:0] = cmp_q;
      REG_STAT:  rd_mux[0]         = match;
      default:   rd_mux            = '0;
    endcase
  end

  // Response is prepared in the first access cycle; writes land when pready is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      pready          <= 1'b0;
      prdata          <= '0;
      pslverr         <= 1'b0;
      ctrl_en         <= 1'b0;
      ctrl_autoreload <= 1'b0;
      ctrl_irq_en     <= 1'b0;
      ctrl_presc      <= '0;
      cmp_q           <= '0;
    end else begin
      pready  <= access;
      pslverr <= access & (sel == REG_NONE);
      if (access && !pwrite) prdata <= rd_mux;
      if (wr_commit && sel == REG_CTRL) begin
        ctrl_en         <= pwdata[CTRL_EN_BIT];
        ctrl_autoreload <= pwdata[CTRL_AUTORELOAD_BIT];
        ctrl_irq_en     <= pwdata[CTRL_IRQ_EN_BIT];
        ctrl_presc      <= pwdata[CTRL_PRESC_LSB +: PRE_W];
      end
      if (wr_commit && sel == REG_CMP) cmp_q <= pwdata[CNT_W-1:0];
    end
  end

  apb_timer_core #(
    .CNT_W(CNT_W),
    .PRE_W(PRE_W)
  ) u_core (
    .clk        (clk),
    .rst        (rst),
    .en         (ctrl_en),
    .autoreload (ctrl_autoreload),
    .presc      (ctrl_presc),
    .cmp        (cmp_q),
    .count_we   (wr_commit && sel == REG_COUNT),
    .count_wdata(pwdata[CNT_W-1:0]),
    .match_clr  (wr_commit && sel == REG_STAT && pwdata[0]),
    .count      (count),
    .match      (match)
  );

  assign irq = match & ctrl_irq_en;

endmodule

// File: tb/tb_apb_timer.sv
// Randomized APB bench for apb_timer with a tick-level reference model.
module tb_apb_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  apb_timer dut (
    .clk    (clk),
    .rst    (rst),
    .paddr  (paddr),
    .psel   (psel),
    .penable(penable),
    .pwrite (pwrite),
    .pwdata (pwdata),
    .pready (pready),
    .prdata (prdata),
    .pslverr(pslverr),
    .irq    (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference state, valid just after edge m_edge.
  logic [31:0] m_count, m_cmp, last_rd;
  bit          m_match, m_en, m_ar, m_ie, m_tick_end_match;
  int          m_p, m_pm, m_edge;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got 0x%08h, expected 0x%08h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_count = 0; m_cmp = 0; m_match = 0; m_en = 0; m_ar = 0; m_ie = 0;
    m_p = 0; m_pm = 0; m_edge = cyc; last_rd = 0; m_tick_end_match = 0;
  endtask

  // Advance to edge e: count the ticks arithmetically, then apply the tick rule per tick.
  task automatic model_adv(input int e);
    int n, k1, ticks;
    n = e - m_edge;
    if (n <= 0) return;
    m_tick_end_match = 0;
    if (!m_en) m_pm = 0;
    else begin
      k1 = (m_pm >= m_p) ? 1 : m_p - m_pm + 1;
      if (n < k1) begin
        ticks = 0;
        m_pm  = m_pm + n;
      end else begin
        ticks = 1 + (n - k1) / (m_p + 1);
        m_pm  = (n - k1) % (m_p + 1);
      end
      for (int i = 0; i < ticks; i++) begin
        m_tick_end_match = (m_count == m_cmp);
        if (m_count == m_cmp) begin
          m_match = 1;
          m_count = m_ar ? 32'h0 : m_count + 1;
        end else m_count = m_count + 1;
      end
      if (ticks == 0 || m_pm != 0) m_tick_end_match = 0;
    end
    m_edge = e;
  endtask

  function automatic logic [31:0] model_read(input logic [11:0] addr);
    logic [7:0] p8;
    p8 = 8'(m_p);
    case (addr[3:2])
      2'd0:    return {16'h0, p8, 5'b0, m_ie, m_ar, m_en};
      2'd1:    return m_count;
      2'd2:    return m_cmp;
      default: return {31'b0, m_match};
    endcase
  endfunction

  task automatic model_write(input logic [11:0] addr, input logic [31:0] wd);
    case (addr[3:2])
      2'd0: begin
        m_en = wd[0]; m_ar = wd[1]; m_ie = wd[2]; m_p = int'(wd[15:8]);
      end
      2'd1: begin m_count = wd; m_pm = 0; end
      2'd2: m_cmp = wd;
      default: if (wd[0] && !m_tick_end_match) m_match = 0;
    endcase
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Full transfer: setup, access (wait state), completion, then bus idle.
  task automatic xfer(input logic [11:0] addr, input bit wr, input logic [31:0] wd,
                      output logic [31:0] rd, output logic err,
                      output int rd_edge, output int wr_edge);
    paddr = addr; pwrite = wr; pwdata = wd; psel = 1; penable = 0;
    @(posedge clk); #1;
    penable = 1;
    chk("pready_setup", 32'(pready), 32'h0);
    @(posedge clk); #1;
    chk("pready_done", 32'(pready), 32'h1);
    rd = prdata; err = pslverr;
    rd_edge = cyc - 1;
    wr_edge = cyc + 1;
    @(posedge clk); #1;
    psel = 0; penable = 0;
    chk("pready_drop", 32'(pready), 32'h0);
    chk("pslverr_idle", 32'(pslverr), 32'h0);
  endtask

  task automatic do_op(input logic [11:0] addr, input bit wr, input logic [31:0] wd);
    logic [31:0] rd, exp;
    logic        err;
    int          rde, wre;
    bit          bad;
    bad = (addr[11:4] != 8'h0);
    xfer(addr, wr, wd, rd, err, rde, wre);
    chk("pslverr", 32'(err), 32'(bad));
    if (!wr) begin
      model_adv(rde);
      exp = bad ? 32'h0 : model_read(addr);
      chk(bad ? "rd_bad" : "rd_reg", rd, exp);
      last_rd = exp;
    end else begin
      chk("prdata_held", rd, last_rd);
      model_adv(wre);
      if (!bad) model_write(addr, wd);
    end
    model_adv(cyc);
    chk("irq", 32'(irq), 32'(m_match & m_ie));
  endtask

  task automatic rand_op();
    logic [31:0] wd;
    logic [11:0] lo;
    int          k;
    lo = 12'($urandom_range(0, 3));
    k  = $urandom_range(0, 9);
    case (k)
      0: begin
        wd = $urandom;
        wd[15:8] = 8'($urandom_range(0, 5));
        wd[0] = ($urandom_range(0, 3) != 0);
        do_op(12'h000 | lo, 1, wd);
      end
      1, 2: begin
        case ($urandom_range(0, 2))
          0:       wd = m_cmp - 32'($urandom_range(0, 4));
          1:       wd = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
          default: wd = $urandom;
        endcase
        do_op(12'h004 | lo, 1, wd);
      end
      3: do_op(12'h008 | lo, 1, ($urandom_range(0, 3) != 0) ? 32'($urandom_range(0, 12)) : $urandom);
      4: do_op(12'h00C | lo, 1, $urandom);
      5, 6, 7: do_op(12'({$urandom_range(0, 3), 2'b00}) | lo, 0, 32'h0);
      8: do_op(12'({$urandom_range(4, 1023), 2'b00}) | lo, 1'($urandom_range(0, 1)), $urandom);
      default: begin
        idle($urandom_range(1, 10));
        model_adv(cyc);
        chk("irq_idle", 32'(irq), 32'(m_match & m_ie));
      end
    endcase
    idle($urandom_range(0, 3));
  endtask

  initial begin
    rst = 1; psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pready", 32'(pready), 32'h0);
    chk("rst_prdata", prdata, 32'h0);
    chk("rst_pslverr", 32'(pslverr), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    rst = 0;
    model_reset();

    for (int a = 0; a < 4; a++) do_op(12'(a * 4), 0, 32'h0);

    // Compare/auto-reload with prescaler 0, then clear the flag.
    do_op(12'h008, 1, 32'd3);
    do_op(12'h000, 1, 32'h0000_0007);
    for (int i = 0; i < 6; i++) begin
      do_op(12'h004, 0, 32'h0);
      do_op(12'h00C, 0, 32'h0);
    end
    do_op(12'h00C, 1, 32'h1);

    // Wrap through 0xFFFF_FFFF with PRESC=4.
    do_op(12'h008, 1, 32'd5);
    do_op(12'h000, 1, 32'h0000_0401);
    do_op(12'h004, 1, 32'hFFFF_FFFE);
    for (int i = 0; i < 6; i++) begin
      idle(2);
      do_op(12'h004, 0, 32'h0);
    end
    do_op(12'h00C, 0, 32'h0);

    // Unmapped offsets.
    do_op(12'h010, 0, 32'h0);
    do_op(12'hFFC, 1, 32'h0000_DEAD);
    for (int a = 0; a < 4; a++) do_op(12'(a * 4), 0, 32'h0);

    for (int i = 0; i < 250; i++) rand_op();

    // Reset in the middle of an access, with non-zero state beforehand.
    do_op(12'h008, 1, 32'd9);
    do_op(12'h000, 1, 32'h0000_0507);
    paddr = 12'h004; pwrite = 0; psel = 1; penable = 0;
    @(posedge clk); #1;
    penable = 1; rst = 1;
    @(posedge clk); #1;
    chk("rst_mid_pready", 32'(pready), 32'h0);
    chk("rst_mid_prdata", prdata, 32'h0);
    chk("rst_mid_irq", 32'(irq), 32'h0);
    psel = 0; penable = 0; rst = 0;
    model_reset();
    for (int a = 0; a < 4; a++) do_op(12'(a * 4), 0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
